mig_calib_monitor: RTL and testbench

- Consumes the memory controller's post-reset status (calibration complete, UI sync reset) and drives the enable of the MIG reset hold timer.
- Releases the downstream system reset only after calibration is stable.
- On calibration timeout or calibration loss, drops the timer enable to re-run the full MIG reset sequence, up to a retry limit, then latches an error.
- Sits between the MIG status outputs and all DDR-dependent logic.

---
 rtl/mig_calib_monitor.sv | 195 +++++++++++++++++++
 tb/tb_mig_calib_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_calib_monitor.sv
// mig_calib_monitor
// Watches the MIG post-reset status and gates the downstream system reset.
// The MIG reset hold timer is enabled, calibration is awaited, and the
// system reset is released only after a run of consecutive good status
// cycles. A timeout or a loss of calibration drops the timer enable so the
// full MIG reset sequence runs again. Once the retry budget is spent, a
// sticky error is latched.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_ASSERT | timer enable held low for RETRY_LOW_CYCLES, MIG kept in reset
// ST_WAIT   | timer enabled, waiting for calib complete with no UI reset
// ST_STABLE | status good, counting consecutive good cycles before release
// ST_RUN    | system reset released, ready asserted
// ST_ERROR  | retries exhausted, everything held off until i_Reset_n
//
// A fault (a timeout in WAIT/STABLE, or bad status in RUN) is not a state.
// It is decided in a single cycle: go to ST_ASSERT with one more retry
// consumed, or go to ST_ERROR once the retry count has reached MAX_RETRIES.

module mig_calib_monitor #(
    parameter int CALIB_TIMEOUT_CYCLES = 2000000,
    parameter int TIMEOUT_WIDTH        = 22,
    parameter int STABLE_CYCLES        = 256,
    parameter int STABLE_WIDTH         = 9,
    parameter int RETRY_LOW_CYCLES     = 100,
    parameter int MAX_RETRIES          = 3,
    parameter int RETRY_WIDTH          = 2
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic                   i_Calib_Complete,
    input  logic                   i_Ui_Sync_Rst,
    output logic                   o_Timer_Enable,
    output logic                   o_Sys_Reset_n,
    output logic                   o_Ready,
    output logic                   o_Error,
    output logic [RETRY_WIDTH-1:0] o_Retry_Count
);

    localparam int LOW_WIDTH = (RETRY_LOW_CYCLES > 1) ? $clog2(RETRY_LOW_CYCLES) : 1;

    localparam logic [LOW_WIDTH-1:0]     LOW_LAST     = LOW_WIDTH'(RETRY_LOW_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(CALIB_TIMEOUT_CYCLES - 1);
    localparam logic [STABLE_WIDTH-1:0]  STABLE_LAST  = STABLE_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [RETRY_WIDTH-1:0]   RETRY_MAX    = RETRY_WIDTH'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ASSERT = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                   state;
    logic [LOW_WIDTH-1:0]     low_cnt;
    logic [TIMEOUT_WIDTH-1:0] timeout_cnt;
    logic [STABLE_WIDTH-1:0]  stable_cnt;

    logic calib_meta;
    logic calib_sync;
    logic ui_rst_meta;
    logic ui_rst_sync;

    logic status_good;
    logic stable_done;
    logic timeout_hit;
    logic fault_now;
    logic retries_spent;

    // Two-flop synchronizers. The UI reset resets to 1 so that the status
    // reads as bad until the MIG says otherwise.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            calib_meta  <= 1'b0;
            calib_sync  <= 1'b0;
            ui_rst_meta <= 1'b1;
            ui_rst_sync <= 1'b1;
        end else begin
            calib_meta  <= i_Calib_Complete;
            calib_sync  <= calib_meta;
            ui_rst_meta <= i_Ui_Sync_Rst;
            ui_rst_sync <= ui_rst_meta;
        end
    end

    // Fault decision. A completed stable count outranks a timeout that
    // lands on the same cycle.
    always_comb begin
        status_good   = calib_sync & ~ui_rst_sync;
        stable_done   = status_good && (stable_cnt == STABLE_LAST);
        timeout_hit   = (timeout_cnt == TIMEOUT_LAST);
        retries_spent = (o_Retry_Count == RETRY_MAX);
        fault_now     = 1'b0;
        case (state)
            ST_WAIT:   fault_now = !status_good && timeout_hit;
            ST_STABLE: fault_now = !stable_done && timeout_hit;
            ST_RUN:    fault_now = !status_good;
            default:   fault_now = 1'b0;
        endcase
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state          <= ST_ASSERT;
            low_cnt        <= '0;
            timeout_cnt    <= '0;
            stable_cnt     <= '0;
            o_Timer_Enable <= 1'b0;
            o_Sys_Reset_n  <= 1'b0;
            o_Ready        <= 1'b0;
            o_Error        <= 1'b0;
            o_Retry_Count  <= '0;
        end else if (fault_now) begin
            o_Timer_Enable <= 1'b0;
            o_Sys_Reset_n  <= 1'b0;
            o_Ready        <= 1'b0;
            low_cnt        <= '0;
            if (retries_spent) begin
                state   <= ST_ERROR;
                o_Error <= 1'b1;
            end else begin
                state         <= ST_ASSERT;
                o_Retry_Count <= o_Retry_Count + 1'b1;
            end
        end else begin
            case (state)
                ST_ASSERT: begin
                    o_Timer_Enable <= 1'b0;
                    o_Sys_Reset_n  <= 1'b0;
                    o_Ready        <= 1'b0;
                    if (low_cnt == LOW_LAST) begin
                        low_cnt        <= '0;
                        timeout_cnt    <= '0;
                        state          <= ST_WAIT;
                        o_Timer_Enable <= 1'b1;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    o_Timer_Enable <= 1'b1;
                    timeout_cnt    <= timeout_cnt + 1'b1;
                    if (status_good) begin
                        stable_cnt <= '0;
                        state      <= ST_STABLE;
                    end
                end

                ST_STABLE: begin
                    o_Timer_Enable <= 1'b1;
                    // The timeout keeps running through STABLE. It holds at its
                    // terminal value only when RUN wins the tie.
                    if (!timeout_hit) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                    if (!status_good) begin
                        state <= ST_WAIT;
                    end else if (stable_done) begin
                        state         <= ST_RUN;
                        o_Sys_Reset_n <= 1'b1;
                        o_Ready       <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    o_Timer_Enable <= 1'b1;
                    o_Sys_Reset_n  <= 1'b1;
                    o_Ready        <= 1'b1;
                end

                ST_ERROR: begin
                    o_Timer_Enable <= 1'b0;
                    o_Sys_Reset_n  <= 1'b0;
                    o_Ready        <= 1'b0;
                    o_Error        <= 1'b1;
                end

                default: begin
                    state          <= ST_ASSERT;
                    low_cnt        <= '0;
                    o_Timer_Enable <= 1'b0;
                    o_Sys_Reset_n  <= 1'b0;
                    o_Ready        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mig_calib_monitor.sv
// Directed bench for mig_calib_monitor with small timing parameters.
// Inputs change 1 time unit after each rising edge, and outputs are sampled
// at that same point.
// Latency notes: a change driven after edge k is in calib_sync after edge
// k+2, so the FSM acts on it at edge k+3. Release comes 16 edges after
// STABLE entry, which gives 19 steps from the calib rise.

module tb_mig_calib_monitor;

    localparam int TO_CYC  = 1000;
    localparam int TO_W    = 10;
    localparam int ST_CYC  = 16;
    localparam int ST_W    = 5;
    localparam int LOW_CYC = 10;
    localparam int MAX_RT  = 2;
    localparam int RT_W    = 2;

    localparam int SIG_TEN = 0;
    localparam int SIG_SYS = 1;
    localparam int SIG_RDY = 2;
    localparam int SIG_ERR = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            calib;
    logic            ui_rst;
    logic            timer_en;
    logic            sys_rst_n;
    logic            ready;
    logic            error;
    logic [RT_W-1:0] retry_cnt;

    int n_pass  = 0;
    int n_total = 0;

    mig_calib_monitor #(
        .CALIB_TIMEOUT_CYCLES(TO_CYC),
        .TIMEOUT_WIDTH       (TO_W),
        .STABLE_CYCLES       (ST_CYC),
        .STABLE_WIDTH        (ST_W),
        .RETRY_LOW_CYCLES    (LOW_CYC),
        .MAX_RETRIES         (MAX_RT),
        .RETRY_WIDTH         (RT_W)
    ) dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_Calib_Complete(calib),
        .i_Ui_Sync_Rst   (ui_rst),
        .o_Timer_Enable  (timer_en),
        .o_Sys_Reset_n   (sys_rst_n),
        .o_Ready         (ready),
        .o_Error         (error),
        .o_Retry_Count   (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pre_delay;   // cycles after timer enable rises before the first calib rise
        int pulse_hi;    // first calib pulse length (0 = no glitch)
        int pulse_lo;    // length of the bad-status gap after that pulse
        int on_ui;       // 1: the gap comes from ui_rst with calib held high
        int exp_rel;     // steps from the final good rise to sys_rst_n high
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            SIG_TEN: return timer_en;
            SIG_SYS: return sys_rst_n;
            SIG_RDY: return ready;
            default: return error;
        endcase
    endfunction

    // Steps until the selected output equals lvl. A missing event leaves
    // n == limit, and the caller's check then fails.
    task automatic count_until(input int which, input logic lvl, input int limit, output int n);
        n = 0;
        while (sig(which) !== lvl && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        calib  = 1'b0;
        ui_rst = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int early;
        int bad;

        vecs[0] = '{200, 0,  0, 0, 19};  // nominal bring-up
        vecs[1] = '{50,  8,  3, 0, 19};  // short glitch during calibration
        vecs[2] = '{30,  16, 1, 0, 19};  // one good cycle short of release
        vecs[3] = '{40,  10, 2, 1, 19};  // glitch from the UI reset
        vecs[4] = '{0,   0,  0, 0, 19};  // calib already up when enabled

        rst_n  = 1'b0;
        calib  = 1'b0;
        ui_rst = 1'b0;
        #1;
        check("rst_timer_en", timer_en, 0);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_error", error, 0);
        check("rst_retry", retry_cnt, 0);

        // Table-driven bring-ups
        for (int i = 0; i < 5; i++) begin
            apply_reset();
            count_until(SIG_TEN, 1'b1, 50, n);
            check($sformatf("v%0d_ten_rise", i), n, LOW_CYC);
            repeat (vecs[i].pre_delay) step();
            early = 0;
            if (vecs[i].pulse_hi > 0) begin
                calib = 1'b1;
                repeat (vecs[i].pulse_hi) begin
                    step();
                    if (sys_rst_n) early = 1;
                end
                if (vecs[i].on_ui != 0) ui_rst = 1'b1;
                else calib = 1'b0;
                repeat (vecs[i].pulse_lo) begin
                    step();
                    if (sys_rst_n) early = 1;
                end
            end
            calib  = 1'b1;
            ui_rst = 1'b0;
            count_until(SIG_SYS, 1'b1, 100, n);
            check($sformatf("v%0d_no_early", i), early, 0);
            check($sformatf("v%0d_release", i), n, vecs[i].exp_rel);
            check($sformatf("v%0d_ready", i), ready, 1);
            check($sformatf("v%0d_ten", i), timer_en, 1);
            check($sformatf("v%0d_retry", i), retry_cnt, 0);
            check($sformatf("v%0d_error", i), error, 0);
        end

        // Boundary tie: STABLE entry at W0+984 means the 16th count lands on
        // W0+1000, the same edge where the timeout counter is at 999.
        apply_reset();
        count_until(SIG_TEN, 1'b1, 50, n);
        repeat (981) step();
        calib = 1'b1;
        repeat (18) step();
        check("tie_pre_sys", sys_rst_n, 0);
        check("tie_pre_ten", timer_en, 1);
        step();
        check("tie_sys", sys_rst_n, 1);
        check("tie_ready", ready, 1);
        check("tie_ten", timer_en, 1);
        check("tie_retry", retry_cnt, 0);

        // One cycle later, the timeout wins.
        apply_reset();
        count_until(SIG_TEN, 1'b1, 50, n);
        repeat (982) step();
        calib = 1'b1;
        repeat (18) step();
        check("late_ten", timer_en, 0);
        check("late_sys", sys_rst_n, 0);
        check("late_retry", retry_cnt, 1);

        // No calibration: two retries, then a sticky error.
        apply_reset();
        count_until(SIG_TEN, 1'b1, 50, n);
        for (int r = 1; r <= MAX_RT; r++) begin
            count_until(SIG_TEN, 1'b0, 1100, n);
            check($sformatf("nocal%0d_enabled", r), n, TO_CYC);
            check($sformatf("nocal%0d_retry", r), retry_cnt, r);
            count_until(SIG_TEN, 1'b1, 50, n);
            check($sformatf("nocal%0d_low", r), n, LOW_CYC);
        end
        count_until(SIG_TEN, 1'b0, 1100, n);
        check("nocal3_enabled", n, TO_CYC);
        check("nocal3_error", error, 1);
        calib = 1'b1;
        bad = 0;
        repeat (50) begin
            step();
            if (timer_en || sys_rst_n || ready || !error || retry_cnt != 2'(MAX_RT)) bad++;
        end
        check("err_terminal_bad_cycles", bad, 0);

        // Calibration loss in RUN from a single-cycle UI reset pulse.
        apply_reset();
        count_until(SIG_TEN, 1'b1, 50, n);
        calib = 1'b1;
        count_until(SIG_SYS, 1'b1, 100, n);
        check("loss_first_release", n, 19);
        ui_rst = 1'b1;
        step();
        ui_rst = 1'b0;
        count_until(SIG_SYS, 1'b0, 10, n);
        check("loss_sys_fall", n + 1, 3);
        check("loss_ready", ready, 0);
        check("loss_ten", timer_en, 0);
        check("loss_retry", retry_cnt, 1);
        count_until(SIG_TEN, 1'b1, 50, n);
        check("loss_low", n, LOW_CYC);
        count_until(SIG_SYS, 1'b1, 100, n);
        check("loss_rerelease", n, 17);
        check("loss_retry_kept", retry_cnt, 1);

        // A second loss leaves calib low, so the FSM is in WAIT when the async
        // reset arrives between clock edges.
        calib  = 1'b0;
        ui_rst = 1'b1;
        step();
        ui_rst = 1'b0;
        count_until(SIG_SYS, 1'b0, 10, n);
        check("loss2_sys_fall", n + 1, 3);
        check("loss2_retry", retry_cnt, 2);
        count_until(SIG_TEN, 1'b1, 50, n);
        repeat (20) step();
        check("wait_ten_before_rst", timer_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ten", timer_en, 0);
        check("async_sys", sys_rst_n, 0);
        check("async_ready", ready, 0);
        check("async_error", error, 0);
        check("async_retry", retry_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        count_until(SIG_TEN, 1'b1, 50, n);
        check("restart_ten_rise", n, LOW_CYC);
        calib = 1'b1;
        count_until(SIG_SYS, 1'b1, 100, n);
        check("restart_release", n, 19);
        check("restart_retry", retry_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
